// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gen_pkg
// Purpose  : Shared types and helpers for the pulse train generator.
//            - state_t : burst sequencer states
//            - MIN_LEN : shortest legal high/low phase in cycles
//            - eff_len : maps a programmed phase length to its effective
//                        length (a programmed 0 behaves as 1)
// Revision : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int unsigned MIN_LEN = 1;

  function automatic int unsigned eff_len(input int unsigned len);
    eff_len = (len < MIN_LEN) ? MIN_LEN : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : rise_edge_det
// Purpose  : Registered rising-edge detector with asynchronous active-low
//            reset. Keeps one cycle of input history and flags the cycle in
//            which the input is high but was low on the previous clock.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            sig   - input level to watch
//            rise  - high in the cycle a rising edge is seen
// Revision : 1.0 - initial release
// ============================================================================
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  // Set once the input has been seen low after reset. An input already held
  // high across reset release must fall and rise again before it counts.
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      armed <= armed | ~sig;
    end
  end

  assign rise = sig & ~sig_q & armed;

endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Purpose  : On a rising edge of load, emits num_pulses pulses on K, each
//            high for max(high_len,1) cycles and low for max(low_len,1)
//            cycles, then a one-cycle done strobe. Supports abort and an
//            optional retrigger mode (RETRIG=1).
// Ports    : CLK        - rising-edge clock
//            reset      - asynchronous active-low reset
//            load       - start request (rising edge only)
//            num_pulses - pulses per burst, latched at start
//            high_len   - high cycles per pulse, latched at start
//            low_len    - low cycles per pulse, latched at start
//            abort      - synchronous cancel of a running burst
//            K          - registered pulse train
//            busy       - high from the first K=1 cycle to the last low cycle
//            done       - one-cycle strobe at burst completion
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 4,
  parameter int RETRIG = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic             abort,
  output logic             K,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             start;
  logic             accept;
  logic [LEN_W-1:0] high_eff;
  logic [LEN_W-1:0] low_eff;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [LEN_W-1:0] phase;
  logic [LEN_W-1:0] high_lat;
  logic [LEN_W-1:0] low_lat;

  rise_edge_det u_load_edge (
    .clk   (CLK),
    .rst_n (reset),
    .sig   (load),
    .rise  (start)
  );

  assign high_eff = LEN_W'(eff_len(32'(high_len)));
  assign low_eff  = LEN_W'(eff_len(32'(low_len)));

  // A start is taken when idle, in the done cycle, or mid-burst when
  // retriggering is enabled. Abort has priority and is handled first below.
  assign accept = start && ((state == IDLE) || (state == FIN) || (RETRIG != 0));

  // phase counts down the cycles left in the current HIGH/LOW phase
  // (loaded with length-1), remaining counts pulses not yet completed.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      phase     <= '0;
      high_lat  <= '0;
      low_lat   <= '0;
      K         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        remaining <= '0;
        phase     <= '0;
        K         <= 1'b0;
        busy      <= 1'b0;
      end else if (accept) begin
        high_lat <= high_eff;
        low_lat  <= low_eff;
        if (num_pulses != '0) begin
          state     <= HIGH;
          remaining <= num_pulses;
          phase     <= high_eff - LEN_ONE;
          K         <= 1'b1;
          busy      <= 1'b1;
        end else begin
          // Empty burst: no pulse, straight to the completion strobe.
          state     <= FIN;
          remaining <= '0;
          phase     <= '0;
          K         <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
      end else begin
        case (state)
          HIGH: begin
            if (phase == '0) begin
              state <= LOW;
              phase <= low_lat - LEN_ONE;
              K     <= 1'b0;
            end else begin
              phase <= phase - LEN_ONE;
            end
          end
          LOW: begin
            if (phase == '0) begin
              if (remaining == CNT_ONE) begin
                state     <= FIN;
                remaining <= '0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                state     <= HIGH;
                remaining <= remaining - CNT_ONE;
                phase     <= high_lat - LEN_ONE;
                K         <= 1'b1;
              end
            end else begin
              phase <= phase - LEN_ONE;
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Purpose  : Self-checking bench for pulse_train_gen. Two instances share
//            all inputs: one with RETRIG=0 and one with RETRIG=1. A queue
//            based reference model predicts {K,busy,done} per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

  logic       CLK = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] num_pulses;
  logic [3:0] high_len;
  logic [3:0] low_len;
  logic       abort;
  logic       K0, busy0, done0;
  logic       K1, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  pulse_train_gen #(.CNT_W(8), .LEN_W(4), .RETRIG(0)) u_dut0 (
    .CLK(CLK), .reset(reset), .load(load), .num_pulses(num_pulses),
    .high_len(high_len), .low_len(low_len), .abort(abort),
    .K(K0), .busy(busy0), .done(done0)
  );

  pulse_train_gen #(.CNT_W(8), .LEN_W(4), .RETRIG(1)) u_dut1 (
    .CLK(CLK), .reset(reset), .load(load), .num_pulses(num_pulses),
    .high_len(high_len), .low_len(low_len), .abort(abort),
    .K(K1), .busy(busy1), .done(done1)
  );

  // ---------------- reference model ----------------
  // Each queue entry is the {K,busy,done} expected in one future cycle;
  // entry 0 is the current cycle. An empty queue means idle (all zero).
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] nb[$];
  logic       m_prev;
  logic       m_armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_prev  = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic build_burst();
    int h, l;
    h = (high_len == 0) ? 1 : int'(high_len);
    l = (low_len  == 0) ? 1 : int'(low_len);
    nb.delete();
    for (int p = 0; p < int'(num_pulses); p++) begin
      for (int i = 0; i < h; i++) nb.push_back(3'b110);
      for (int i = 0; i < l; i++) nb.push_back(3'b010);
    end
    nb.push_back(3'b001);
  endtask

  // Called at each rising clock edge with the inputs sampled at that edge.
  task automatic model_step();
    logic st, busy_now0, busy_now1;
    st = load && !m_prev && m_armed;
    busy_now0 = (q0.size() > 0) && q0[0][1];
    busy_now1 = (q1.size() > 0) && q1[0][1];
    if (q0.size() > 0) void'(q0.pop_front());
    if (q1.size() > 0) void'(q1.pop_front());
    build_burst();
    if (abort) begin
      q0.delete();
      q1.delete();
    end else if (st) begin
      if (!busy_now0) q0 = nb;
      q1 = nb;
    end
    m_armed = m_armed | !load;
    m_prev  = load;
  endtask

  task automatic model_check();
    logic [2:0] e0, e1;
    e0 = (q0.size() > 0) ? q0[0] : 3'b000;
    e1 = (q1.size() > 0) ? q1[0] : 3'b000;
    check("model_dut0", {29'd0, K0, busy0, done0}, {29'd0, e0});
    check("model_dut1", {29'd0, K1, busy1, done1}, {29'd0, e1});
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic step();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    model_check();
  endtask

  // ---------------- table-driven bursts ----------------
  typedef struct {
    logic [7:0]  n;
    logic [3:0]  h;
    logic [3:0]  l;
    int          exp_busy;
    logic [31:0] exp_pat;
  } vec_t;

  vec_t vecs[6];

  // Launches a burst, then captures busy length, the K pattern during busy,
  // and the done strobe position on the RETRIG=0 instance.
  task automatic run_burst(input int idx, input logic [7:0] n, input logic [3:0] h,
                           input logic [3:0] l, input int exp_busy, input logic [31:0] exp_pat);
    int          bcnt, dcnt, dcyc;
    logic        first_k;
    logic [31:0] pat;
    bcnt = 0; dcnt = 0; dcyc = -1; pat = '0; first_k = 1'b0;
    num_pulses = n; high_len = h; low_len = l; load = 1'b1;
    step();
    for (int c = 1; c <= 80; c++) begin
      if (busy0) begin
        bcnt++;
        pat = {pat[30:0], K0};
      end
      if (done0) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == 1) first_k = K0;
      if (c >= 3) load = 1'b0;
      if (c >= 2) begin
        num_pulses = 8'($urandom_range(0, 9));
        high_len   = 4'($urandom_range(0, 15));
        low_len    = 4'($urandom_range(0, 15));
      end
      if (dcyc > 0 && c > dcyc + 1) break;
      step();
    end
    check($sformatf("vec%0d_busy_len", idx), bcnt, exp_busy);
    check($sformatf("vec%0d_k_pattern", idx), pat, exp_pat);
    check($sformatf("vec%0d_done_count", idx), dcnt, 1);
    check($sformatf("vec%0d_done_cycle", idx), dcyc, exp_busy + 1);
    check($sformatf("vec%0d_first_k", idx), {31'd0, first_k}, {31'd0, (n != 0)});
    load = 1'b0;
  endtask

  initial begin
    int ones0, ones1, ones1_after, bsy0, bsy1, dn0, dn1, dseen;

    vecs[0] = '{n: 8'd5, h: 4'd1,  l: 4'd1,  exp_busy: 10, exp_pat: 32'h0000_02AA};
    vecs[1] = '{n: 8'd3, h: 4'd2,  l: 4'd3,  exp_busy: 15, exp_pat: 32'h0000_6318};
    vecs[2] = '{n: 8'd0, h: 4'd4,  l: 4'd4,  exp_busy: 0,  exp_pat: 32'h0000_0000};
    vecs[3] = '{n: 8'd2, h: 4'd0,  l: 4'd0,  exp_busy: 4,  exp_pat: 32'h0000_000A};
    vecs[4] = '{n: 8'd1, h: 4'd15, l: 4'd15, exp_busy: 30, exp_pat: 32'h3FFF_8000};
    vecs[5] = '{n: 8'd4, h: 4'd3,  l: 4'd1,  exp_busy: 16, exp_pat: 32'h0000_EEEE};

    reset = 1'b0; load = 1'b0; abort = 1'b0;
    num_pulses = '0; high_len = '0; low_len = '0;
    model_reset();
    #3;
    check("reset_dut0", {29'd0, K0, busy0, done0}, 32'd0);
    check("reset_dut1", {29'd0, K1, busy1, done1}, 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    step();
    step();

    // ---- table-driven bursts ----
    for (int i = 0; i < 6; i++) begin
      run_burst(i, vecs[i].n, vecs[i].h, vecs[i].l, vecs[i].exp_busy, vecs[i].exp_pat);
      step();
    end

    // ---- abort on cycle 4, then a clean burst ----
    num_pulses = 8'd5; high_len = 4'd1; low_len = 4'd1; load = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    abort = 1'b1;
    step();
    check("abort_k", {31'd0, K0}, 32'd0);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    abort = 1'b0;
    dseen = 0;
    for (int c = 0; c < 8; c++) begin
      dseen += int'(done0) + int'(done1);
      step();
    end
    check("abort_no_done", dseen, 0);
    run_burst(6, 8'd5, 4'd1, 4'd1, 10, 32'h0000_02AA);
    step();

    // ---- second load edge mid-burst: ignored vs retrigger ----
    ones0 = 0; ones1 = 0; ones1_after = 0; bsy0 = 0; bsy1 = 0; dn0 = 0; dn1 = 0;
    num_pulses = 8'd5; high_len = 4'd1; low_len = 4'd1; load = 1'b1;
    step();
    for (int c = 1; c <= 40; c++) begin
      ones0 += int'(K0); ones1 += int'(K1);
      bsy0 += int'(busy0); bsy1 += int'(busy1);
      dn0 += int'(done0); dn1 += int'(done1);
      if (c >= 5) ones1_after += int'(K1);
      if (c == 2) load = 1'b0;
      if (c == 4) load = 1'b1;
      if (c == 6) load = 1'b0;
      step();
    end
    check("retrig0_pulses", ones0, 5);
    check("retrig0_busy", bsy0, 10);
    check("retrig0_done", dn0, 1);
    check("retrig1_pulses_after", ones1_after, 5);
    check("retrig1_pulses_total", ones1, 7);
    check("retrig1_busy", bsy1, 14);
    check("retrig1_done", dn1, 1);

    // ---- asynchronous reset mid-HIGH, load held high across it ----
    num_pulses = 8'd5; high_len = 4'd3; low_len = 4'd2; load = 1'b1;
    step();
    step();
    @(posedge CLK);
    model_step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_k", {31'd0, K0}, 32'd0);
    check("async_rst_busy", {31'd0, busy0}, 32'd0);
    check("async_rst_done", {31'd0, done0}, 32'd0);
    @(negedge CLK);
    model_check();
    reset = 1'b1;
    dseen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      dseen += int'(busy0) + int'(busy1) + int'(K0);
    end
    check("held_load_no_burst", dseen, 0);
    load = 1'b0;
    step();
    load = 1'b1;
    step();
    check("reload_after_reset", {30'd0, K0, busy0}, 32'd3);
    load = 1'b0;
    for (int c = 0; c < 100 && q0.size() > 0; c++) step();
    check("reload_burst_finished", q0.size(), 0);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) load = ~load;
      abort      = ($urandom_range(0, 59) == 0);
      num_pulses = 8'($urandom_range(0, 4));
      high_len   = 4'($urandom_range(0, 3));
      low_len    = 4'($urandom_range(0, 3));
      step();
    end
    abort = 1'b0;
    load  = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Parametrised successor of the fixed five-pulse serial-load generator.
- On a rising edge of `load`, emits a programmable number of pulses on `K`, with programmable high and low widths in clock cycles.
- Reports progress through `busy` and `done`; supports abort and an optional retrigger mode.
- Sits in the stimulus path wherever a serial pulse burst is needed; the legacy behaviour is `num_pulses`=5, `high_len`=1, `low_len`=1.

Parameters:
- CNT_W, 8, width of `num_pulses` and of the internal pulse counter; max burst 2^CNT_W-1.
- LEN_W, 4, width of `high_len`/`low_len` and of the phase counter.
- RETRIG, 0, 1 = a `load` edge while busy restarts the burst; 0 = ignored.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- load  input  1  start request; only its rising edge (sampled on CLK) matters.
- num_pulses  input  CNT_W  pulses per burst; latched on the start edge.
- high_len  input  LEN_W  cycles K is high per pulse; 0 treated as 1; latched.
- low_len  input  LEN_W  cycles K is low after each pulse; 0 treated as 1; latched.
- abort  input  1  synchronous cancel of a running burst.
- K  output  1  pulse train; registered.
- busy  output  1  high from the first K=1 cycle through the last low cycle.
- done  output  1  one-cycle strobe at burst completion.

Behaviour:
- Reset (reset=0, asynchronous): K=0, busy=0, done=0, state IDLE, all counters 0, load history=0. Takes effect immediately, including mid-burst. No `done` is produced for a burst killed by reset.
- Start edge: cycle where load=1 and registered load_q=0.
- States: IDLE, HIGH, LOW, FIN.
- IDLE: on start edge, latch config. If num_pulses≠0, go to HIGH. If num_pulses=0, go to FIN (no K pulse).
- Latency: K=1 and busy=1 appear at the first CLK edge following the cycle in which the start edge was sampled.
- HIGH: K=1 for max(high_len,1) cycles, then LOW.
- LOW: K=0 for max(low_len,1) cycles. Then decrement the remaining-pulse count: if nonzero, go to HIGH; else go to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. A start edge in FIN is accepted as a fresh start.
- Total burst length = N*(H+L) cycles of busy, then 1 cycle of done.
- abort=1 in HIGH/LOW/FIN: next state IDLE, K=0, busy=0, no done strobe.
- abort and start edge in the same cycle: abort wins and the start is discarded.
- Start edge while busy:
  - RETRIG=0: ignored.
  - RETRIG=1: re-latch config and enter HIGH next cycle (K stays/goes 1); the pulse counter reloads.
- Config inputs may change freely while busy; only latched copies are used.
- Counters saturate never; widths follow the parameters; no wrap within a legal burst.
- `load` held high continuously produces only one burst.

Decomposition:
- Package pulse_gen_pkg holds:
  - state enum {IDLE, HIGH, LOW, FIN};
  - localparam MIN_LEN = 1;
  - a function returning max(len,1).
- One sub-module, rise_edge_det: a registered rising-edge detector with async active-low reset, used for `load`.
- The FSM and counters stay in pulse_train_gen.

Test Plan:
- Reset then load rise with N=5, H=1, L=1 -> K = 1010101010 over 10 cycles starting 1 cycle after the edge; busy high for 10 cycles; done=1 on cycle 11; K=0 afterwards.
- N=3, H=2, L=3 -> K pattern 11000 repeated 3 times (15 cycles); single done strobe; busy deasserts in the same cycle done asserts.
- N=0 -> K stays 0, busy stays 0, done=1 exactly one cycle after the start-edge cycle. H=0/L=0 with N=2 -> behaves as H=L=1 (1010).
- abort asserted on cycle 4 of an N=5,H=1,L=1 burst -> K=0 and busy=0 next cycle; no done; a following load edge starts a clean 5-pulse burst.
- RETRIG=0: second load edge mid-burst -> ignored, 5 pulses total. RETRIG=1: the same stimulus -> burst restarts and 5 full pulses follow the second edge; one done strobe at the end.
- reset driven 0 asynchronously mid-HIGH (between clock edges) -> K, busy, done go 0 immediately; after release, `load` held high produces no burst until it falls and rises again.
